// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter and its round-robin picker.
// Contents: FSM state encoding, statistics counter width, ring-index helper.
package fifo_arb_pkg;

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  localparam int unsigned STAT_WIDTH = 16;

  // (idx + 1) mod n for idx already in [0, n-1]; avoids a real divider
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first valid index searched cyclically
// starting at rr_ptr.
// Ports: req_valid (per-requester valid), rr_ptr (search start, < NUM_REQ),
//        winner (selected index), any_valid (at least one valid).
module rr_pick #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any_valid
);

  // Ring search; the first hit in offset order is kept
  always_comb begin
    int unsigned idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req_valid[ID_WIDTH'(idx)]) begin
        winner    = ID_WIDTH'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of a FIFO write port. A granted producer
// may hold the port for up to MAX_BURST beats; each word is tagged with the
// source ID in its MSBs.
// Ports: clk, rst_n (async active-low), req_valid/req_data/req_ready
//        (producer handshakes), fifo_din/fifo_wr_en/fifo_full (FIFO write
//        side), arb_busy (burst lock held).
// Optional: FIFO_ARB_STATS_EN adds stat_clr and stat_cnt (per-producer
//        16-bit saturating beat counters).
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din,
  output logic                           fifo_wr_en,
  input  logic                           fifo_full,
  output logic                           arb_busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                           stat_clr,
  output logic [NUM_REQ*STAT_WIDTH-1:0]  stat_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic [0:0]          state, state_n;
  logic [ID_WIDTH-1:0] rr_ptr, rr_ptr_n;
  logic [ID_WIDTH-1:0] owner, owner_n;
  logic [CNT_W-1:0]    beat_cnt, beat_cnt_n;

  logic [ID_WIDTH-1:0] winner;
  logic                any_valid;
  logic [ID_WIDTH-1:0] grantee;
  logic                granted;
  logic                xfer;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Grant and handshake decode; everything is gated low while in reset
  always_comb begin
    grantee    = (state == LOCK) ? owner : winner;
    granted    = (state == LOCK) || any_valid;
    xfer       = rst_n && granted && req_valid[grantee] && !fifo_full;
    req_ready  = '0;
    if (rst_n && granted && !fifo_full) req_ready[grantee] = 1'b1;
    fifo_wr_en = xfer;
    fifo_din   = '0;
    if (rst_n) fifo_din = {grantee, req_data[32'(grantee)*DATA_WIDTH +: DATA_WIDTH]};
    arb_busy   = rst_n && (state == LOCK);
  end

  // Next-state logic
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    owner_n    = owner;
    beat_cnt_n = beat_cnt;
    case (state)
      ARB: begin
        if (xfer) begin
          if (MAX_BURST == 1) begin
            rr_ptr_n = ID_WIDTH'(next_idx(32'(winner), NUM_REQ));
          end else begin
            state_n    = LOCK;
            owner_n    = winner;
            beat_cnt_n = CNT_W'(1);
          end
        end
      end
      default: begin
        // Owner dropping valid frees the port without a transfer
        if (!req_valid[owner]) begin
          state_n    = ARB;
          rr_ptr_n   = ID_WIDTH'(next_idx(32'(owner), NUM_REQ));
          beat_cnt_n = '0;
        end else if (xfer) begin
          if (32'(beat_cnt) + 1 >= MAX_BURST) begin
            state_n    = ARB;
            rr_ptr_n   = ID_WIDTH'(next_idx(32'(owner), NUM_REQ));
            beat_cnt_n = '0;
          end else begin
            beat_cnt_n = beat_cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      owner    <= owner_n;
      beat_cnt <= beat_cnt_n;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // Per-producer saturating beat counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (stat_clr) begin
          stat_cnt[i*STAT_WIDTH +: STAT_WIDTH] <= '0;
        end else if (xfer && (grantee == ID_WIDTH'(i)) &&
                     (stat_cnt[i*STAT_WIDTH +: STAT_WIDTH] != '1)) begin
          stat_cnt[i*STAT_WIDTH +: STAT_WIDTH] <=
            stat_cnt[i*STAT_WIDTH +: STAT_WIDTH] + STAT_WIDTH'(1);
        end
      end
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios followed by random traffic, all
// compared cycle by cycle against a behavioural arbitration model.
// Optional: FIFO_ARB_STATS_EN enables the statistics-counter scenarios.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int IW = 2;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [IW+DW-1:0]  fifo_din;
  logic              fifo_wr_en;
  logic              fifo_full;
  logic              arb_busy;
`ifdef FIFO_ARB_STATS_EN
  logic              stat_clr;
  logic [N*16-1:0]   stat_cnt;
`endif

  fifo_wr_arb #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full),
    .arb_busy   (arb_busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_cnt   (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Producer drive state
  bit           v [N];
  logic [DW-1:0] d [N];
  bit           stat_clr_drv;

  // Reference model: locked flag, owner, beats taken so far, search start
  bit m_locked;
  int m_owner, m_beats, m_ptr;
  int m_stat [N];

  // Values captured at the sampling point of the latest step
  logic [N-1:0]     acc;
  logic             obs_wr;
  logic [N-1:0]     obs_ready;
  logic [IW+DW-1:0] obs_din;
  logic             obs_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_beats  = 0;
    m_ptr    = 0;
    for (int i = 0; i < N; i++) m_stat[i] = 0;
  endtask

  // Assert reset asynchronously (mid-cycle) with all producers valid
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) v[i] = 1'b1;
    req_valid = '1;
    fifo_full = 1'b0;
    #2;
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_wr_en", 32'(fifo_wr_en), 32'(0));
    check("rst_busy",  32'(arb_busy), 32'(0));
    check("rst_din",   32'(fifo_din), 32'(0));
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    req_valid = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: drive, sample at negedge against the model, advance the model
  task automatic step(input logic full_in);
    logic [N-1:0] vv;
    logic [N-1:0] er;
    bit act, ew;
    int g;
    for (int i = 0; i < N; i++) begin
      vv[i] = v[i];
      req_data[i*DW +: DW] = d[i];
    end
    req_valid = vv;
    fifo_full = full_in;
`ifdef FIFO_ARB_STATS_EN
    stat_clr = stat_clr_drv;
`endif
    @(negedge clk);
    act = 1'b0;
    g   = 0;
    if (m_locked) begin
      act = 1'b1;
      g   = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!act && vv[(m_ptr + k) % N]) begin
          act = 1'b1;
          g   = (m_ptr + k) % N;
        end
      end
    end
    er = '0;
    if (act && !full_in) er[g] = 1'b1;
    ew = act && vv[g] && !full_in;
    obs_wr    = fifo_wr_en;
    obs_ready = req_ready;
    obs_din   = fifo_din;
    obs_busy  = arb_busy;
    check("ready", 32'(obs_ready), 32'(er));
    check("wr_en", 32'(obs_wr), 32'(ew));
    check("busy",  32'(obs_busy), 32'(m_locked));
    if (ew) check("din", 32'(obs_din), 32'({IW'(g), d[g]}));
    acc = '0;
    if (ew) acc[g] = 1'b1;
    if (stat_clr_drv) begin
      for (int i = 0; i < N; i++) m_stat[i] = 0;
    end else if (ew && m_stat[g] < 65535) begin
      m_stat[g]++;
    end
    @(posedge clk);
    if (!m_locked) begin
      if (ew) begin
        if (MB == 1) m_ptr = (g + 1) % N;
        else begin
          m_locked = 1'b1;
          m_owner  = g;
          m_beats  = 1;
        end
      end
    end else if (!vv[m_owner]) begin
      m_locked = 1'b0;
      m_ptr    = (m_owner + 1) % N;
      m_beats  = 0;
    end else if (ew) begin
      m_beats++;
      if (m_beats == MB) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % N;
        m_beats  = 0;
      end
    end
    #1;
  endtask

  // Accepted producers present fresh data
  task automatic refresh();
    for (int i = 0; i < N; i++) if (acc[i]) d[i] = DW'($urandom);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    fifo_full    = 1'b0;
    stat_clr_drv = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr     = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0;
      d[i] = '0;
    end
    model_reset();

    // Reset with all valid, then idle cycles
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step(1'b0);
      check("idle_wr", 32'(obs_wr), 32'(0));
    end

    // Lone streamer on producer 2, across a burst boundary
    v[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d[2] = DW'(16'hA0 + i);
      step(1'b0);
      check("lone_wr",  32'(obs_wr), 32'(1));
      check("lone_din", 32'(obs_din), 32'({2'd2, DW'(16'hA0 + i)}));
    end

    // Reset mid-burst, then fairness with all valid
    do_reset();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1;
      d[i] = DW'($urandom);
    end
    for (int k = 0; k < 17; k++) begin
      step(1'b0);
      check("fair_wr", 32'(obs_wr), 32'(1));
      check("fair_id", 32'(obs_din[DW +: IW]), 32'((k / 4) % 4));
      refresh();
    end
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    step(1'b0);

    // Backpressure on producer 1, producer 2 waiting
    v[1] = 1'b1;
    v[2] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(1'b0);
      check("bp_id", 32'(obs_din[DW +: IW]), 32'(1));
      refresh();
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      check("bp_full_wr",    32'(obs_wr), 32'(0));
      check("bp_full_ready", 32'(obs_ready), 32'(0));
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0);
      check("bp_tail_id", 32'(obs_din[DW +: IW]), 32'(1));
      refresh();
    end
    v[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      check("bp_next_id", 32'(obs_din[DW +: IW]), 32'(2));
      refresh();
    end
    v[2] = 1'b0;

    // Early release: producer 3 for one beat, then producer 0
    v[3] = 1'b1;
    step(1'b0);
    check("er_id", 32'(obs_din[DW +: IW]), 32'(3));
    v[3] = 1'b0;
    v[0] = 1'b1;
    step(1'b0);
    check("er_bubble", 32'(obs_wr), 32'(0));
    step(1'b0);
    check("er_next_wr", 32'(obs_wr), 32'(1));
    check("er_next_id", 32'(obs_din[DW +: IW]), 32'(0));
    v[0] = 1'b0;
    step(1'b0);

    // Random traffic with random FIFO-full
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 5) == 0);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          v[i] = (($urandom % 10) < 7);
          d[i] = DW'($urandom);
        end else if (v[i]) begin
          if (($urandom % 10) == 0) v[i] = 1'b0;
        end else if (($urandom % 10) < 4) begin
          v[i] = 1'b1;
          d[i] = DW'($urandom);
        end
      end
    end

`ifdef FIFO_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < N; i++) v[i] = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step(1'b0);
      refresh();
    end
    for (int i = 0; i < N; i++) begin
      check("stat_model", 32'(stat_cnt[i*16 +: 16]), 32'(m_stat[i]));
      check("stat_eight", 32'(stat_cnt[i*16 +: 16]), 32'(8));
    end
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    stat_clr_drv = 1'b1;
    step(1'b0);
    stat_clr_drv = 1'b0;
    for (int i = 0; i < N; i++) check("stat_clr", 32'(stat_cnt[i*16 +: 16]), 32'(0));
    v[0] = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      step(1'b0);
      refresh();
    end
    check("stat_sat", 32'(stat_cnt[15:0]), 32'(16'hFFFF));
    check("stat_sat_model", 32'(stat_cnt[15:0]), 32'(m_stat[0]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
